// File: rtl/adsr_sched_pkg.sv
// Shared types and constants for the ADSR beat scheduler: FSM states, the
// 60000 ms-per-minute numerator, tempo limits and the tempo clamp helper.
package adsr_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FREE   = 2'd1,
        S_LOCKED = 2'd2
    } sched_state_t;

    localparam int          BPM_NUMER     = 60000;
    localparam logic [15:0] BPM_NUMER_W16 = 16'(BPM_NUMER);
    localparam int          DEF_MIN_BPM   = 40;
    localparam int          DEF_MAX_BPM   = 200;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm, input int lo, input int hi);
        if (int'(bpm) < lo) return 8'(lo);
        if (int'(bpm) > hi) return 8'(hi);
        return bpm;
    endfunction

endpackage

// File: rtl/adsr_beat_scheduler_if.sv
// Control/status bundle of the beat scheduler; master drives the requests,
// slave is the scheduler itself.
interface adsr_beat_scheduler_if;
    logic        enable_in;
    logic        sof;
    logic [7:0]  bpm_in;
    logic        bpm_valid;
    logic [7:0]  amp_in;
    logic        beat_in;
    logic        beat_trigger;
    logic        filter_enable;
    logic [7:0]  bpm_estimate;
    logic [7:0]  pulse_amplitude;
    logic [15:0] period_ms;
    logic        locked;

    modport master (
        output enable_in, sof, bpm_in, bpm_valid, amp_in, beat_in,
        input  beat_trigger, filter_enable, bpm_estimate, pulse_amplitude, period_ms, locked
    );

    modport slave (
        input  enable_in, sof, bpm_in, bpm_valid, amp_in, beat_in,
        output beat_trigger, filter_enable, bpm_estimate, pulse_amplitude, period_ms, locked
    );
endinterface

// File: rtl/adsr_beat_scheduler_div.sv
// Restoring divider, 16-bit dividend by 8-bit divisor: loads on start_i, then
// 16 iterations; done_o/quotient_o are valid together on the last iteration.
module bpm_period_div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [15:0] dividend_i,
    input  logic [7:0]  divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] quotient_o
);
    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [7:0]  rem_q, rem_d, divisor_q;
    logic [15:0] quo_q, quo_d;
    logic [8:0]  trial, diff;
    logic        take;

    // Remainder stays below the divisor, so 8 bits plus the shifted-in bit suffice.
    assign trial = {rem_q, quo_q[15]};
    assign diff  = trial - {1'b0, divisor_q};
    assign take  = (trial >= {1'b0, divisor_q});
    assign rem_d = take ? diff[7:0] : trial[7:0];
    assign quo_d = {quo_q[14:0], take};

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == 5'd1);
    assign quotient_o = quo_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= 5'd0;
            rem_q     <= 8'd0;
            quo_q     <= 16'd0;
            divisor_q <= 8'd0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= 5'd16;
            rem_q     <= 8'd0;
            quo_q     <= dividend_i;
            divisor_q <= divisor_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/adsr_beat_scheduler.sv
// Beat scheduler: free-running beats at 60000/BPM ms, optional lock to beat_in
// (ADSR_SCHED_EXT_LOCK_EN); period_ms lands 17 cycles after bpm_valid.
module adsr_beat_scheduler
    import adsr_sched_pkg::*;
#(
    parameter int PIX_CLK_MHZ    = 25,
    parameter int MIN_BPM        = DEF_MIN_BPM,
    parameter int MAX_BPM        = DEF_MAX_BPM,
    parameter int TRIG_MS        = 4,
    parameter int MS_TICK_CYCLES = PIX_CLK_MHZ * 1000
) (
    input logic                  clk,
    input logic                  reset_n,
    adsr_beat_scheduler_if.slave bus
);
    localparam int          TRIG_CYCLES = TRIG_MS * MS_TICK_CYCLES;
    localparam int          TICK_W      = $clog2(MS_TICK_CYCLES + 1);
    localparam int          TRIG_W      = $clog2(TRIG_CYCLES + 1);
    localparam logic [7:0]  MIN_B8      = 8'(MIN_BPM);
    localparam logic [15:0] PERIOD_RST  = 16'(BPM_NUMER / MIN_BPM);

    sched_state_t      state_q;
    logic              filter_q, locked_q, trig_q;
    logic [TRIG_W-1:0] trig_cnt_q;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [15:0]       phase_q, phase_d, period_q;
    logic [7:0]        bpm_clamp_q, pend_bpm_q, bpm_est_q, amp_q;
    logic              pend_q;

    logic [7:0]  bpm_clamped, div_bpm;
    logic        div_start, div_busy, div_done;
    logic [15:0] div_quot;
    logic        ms_tick, free_due, lock_req, lock_ok, lock_lost, beat_fire;

    assign bpm_clamped = clamp_bpm(bus.bpm_in, MIN_BPM, MAX_BPM);
    // A request queued during a divide is launched as soon as the divider frees up.
    assign div_start   = !div_busy && (bus.bpm_valid || pend_q);
    assign div_bpm     = bus.bpm_valid ? bpm_clamped : pend_bpm_q;

    bpm_period_div u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (div_start),
        .dividend_i(BPM_NUMER_W16),
        .divisor_i (div_bpm),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            pend_bpm_q  <= MIN_B8;
            bpm_clamp_q <= MIN_B8;
            period_q    <= PERIOD_RST;
            bpm_est_q   <= MIN_B8;
            amp_q       <= 8'd0;
        end else begin
            if (bus.bpm_valid) bpm_clamp_q <= bpm_clamped;
            if (bus.bpm_valid && div_busy) begin
                pend_q     <= 1'b1;
                pend_bpm_q <= bpm_clamped;
            end else if (div_start) begin
                pend_q <= 1'b0;
            end
            if (div_done) period_q <= div_quot;
            // Frame-aligned outputs take the tempo accepted before this sof.
            if (bus.sof) begin
                bpm_est_q <= bpm_clamp_q;
                amp_q     <= bus.amp_in;
            end
        end
    end

    assign ms_tick  = (tick_q == TICK_W'(MS_TICK_CYCLES - 1));
    assign free_due = ms_tick && (phase_q == period_q - 16'd1);
`ifdef ADSR_SCHED_EXT_LOCK_EN
    assign lock_req  = bus.beat_in;
    assign lock_ok   = bus.beat_in && (phase_q >= {1'b0, period_q[15:1]});
    assign lock_lost = ms_tick && ({1'b0, phase_q} == {period_q, 1'b0} - 17'd1);
`else
    assign lock_req  = 1'b0;
    assign lock_ok   = 1'b0;
    assign lock_lost = 1'b0;
`endif

    always_comb begin
        beat_fire = 1'b0;
        if (bus.enable_in) begin
            case (state_q)
                S_IDLE:   beat_fire = 1'b1;
                S_FREE:   beat_fire = free_due || lock_req;
                S_LOCKED: beat_fire = lock_ok || lock_lost;
                default:  beat_fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            filter_q <= 1'b0;
            locked_q <= 1'b0;
        end else if (!bus.enable_in) begin
            state_q  <= S_IDLE;
            filter_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_FREE;
                    filter_q <= 1'b1;
                end
                S_FREE: if (lock_req) begin
                    state_q  <= S_LOCKED;
                    locked_q <= 1'b1;
                end
                S_LOCKED: if (lock_lost) begin
                    state_q  <= S_FREE;
                    locked_q <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    filter_q <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Ms tick restarts with the phase so beat-to-beat spacing is exact.
    always_comb begin
        tick_d  = tick_q + TICK_W'(1);
        phase_d = phase_q;
        if (!bus.enable_in || state_q == S_IDLE || beat_fire) begin
            tick_d  = '0;
            phase_d = 16'd0;
        end else if (ms_tick) begin
            tick_d  = '0;
            phase_d = phase_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q     <= '0;
            phase_q    <= 16'd0;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
        end else begin
            tick_q  <= tick_d;
            phase_q <= phase_d;
            if (!bus.enable_in) begin
                trig_q     <= 1'b0;
                trig_cnt_q <= '0;
            end else if (beat_fire) begin
                trig_q     <= 1'b1;
                trig_cnt_q <= TRIG_W'(TRIG_CYCLES - 1);
            end else if (trig_q) begin
                if (trig_cnt_q == '0) trig_q <= 1'b0;
                else trig_cnt_q <= trig_cnt_q - TRIG_W'(1);
            end
        end
    end

    assign bus.beat_trigger    = trig_q;
    assign bus.filter_enable   = filter_q;
    assign bus.locked          = locked_q;
    assign bus.bpm_estimate    = bpm_est_q;
    assign bus.pulse_amplitude = amp_q;
    assign bus.period_ms       = period_q;
endmodule

// File: tb/tb_adsr_beat_scheduler.sv
// Bench for adsr_beat_scheduler with a compressed ms tick (10 cycles per ms);
// stimulus queues expected output events, a negedge monitor checks them.
module tb_adsr_beat_scheduler;
    import adsr_sched_pkg::*;

    localparam int MS       = 10;
    localparam int TRIG_LEN = 4 * MS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adsr_beat_scheduler_if bus();

    adsr_beat_scheduler #(
        .PIX_CLK_MHZ   (1),
        .MIN_BPM       (40),
        .MAX_BPM       (200),
        .TRIG_MS       (4),
        .MS_TICK_CYCLES(MS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t per_q[$];
    ev_t est_q[$];
    ev_t lck_q[$];
    ev_t beat_q[$];

    bit   armed = 1'b0;
    int   prev_per, prev_est, prev_lck, prev_trig;
    int   rise_cyc, exp_len;
    ev_t  e;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: unexpected change to %0d at cycle %0d, expected no change", name, act, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic bpm_req(input int b, input int per);
        bus.bpm_in    = 8'(b);
        bus.bpm_valid = 1'b1;
        per_q.push_back('{cyc + 17, per});
        step(1);
        bus.bpm_valid = 1'b0;
    endtask

    task automatic sof_pulse(input int amp, input int est);
        bus.amp_in = 8'(amp);
        bus.sof    = 1'b1;
        est_q.push_back('{cyc + 1, est * 256 + amp});
        step(1);
        bus.sof = 1'b0;
    endtask

    task automatic ext_beat(input bit accept, input bit lock_change);
        bus.beat_in = 1'b1;
        if (accept) beat_q.push_back('{cyc + 1, TRIG_LEN});
        if (lock_change) lck_q.push_back('{cyc + 1, 1});
        step(1);
        bus.beat_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (int'(bus.period_ms) != prev_per) begin
                if (per_q.size() == 0) unexpected("period_ms", int'(bus.period_ms));
                else begin
                    e = per_q.pop_front();
                    check("period_val", int'(bus.period_ms), e.val);
                    check("period_cycle", cyc, e.cyc);
                end
            end
            if (int'({bus.bpm_estimate, bus.pulse_amplitude}) != prev_est) begin
                if (est_q.size() == 0) unexpected("est_amp", int'({bus.bpm_estimate, bus.pulse_amplitude}));
                else begin
                    e = est_q.pop_front();
                    check("est_amp_val", int'({bus.bpm_estimate, bus.pulse_amplitude}), e.val);
                    check("est_amp_cycle", cyc, e.cyc);
                end
            end
            if (int'(bus.locked) != prev_lck) begin
                if (lck_q.size() == 0) unexpected("locked", int'(bus.locked));
                else begin
                    e = lck_q.pop_front();
                    check("locked_val", int'(bus.locked), e.val);
                    check("locked_cycle", cyc, e.cyc);
                end
            end
            if (bus.beat_trigger && prev_trig == 0) begin
                if (beat_q.size() == 0) begin
                    unexpected("beat_rise", 1);
                    exp_len = TRIG_LEN;
                end else begin
                    e = beat_q.pop_front();
                    check("beat_cycle", cyc, e.cyc);
                    exp_len = e.val;
                end
                rise_cyc = cyc;
            end
            if (!bus.beat_trigger && prev_trig == 1) check("trig_len", cyc - rise_cyc, exp_len);
            prev_per  = int'(bus.period_ms);
            prev_est  = int'({bus.bpm_estimate, bus.pulse_amplitude});
            prev_lck  = int'(bus.locked);
            prev_trig = int'(bus.beat_trigger);
        end
    end

    int t0, b2, b3, k;

    initial begin
        bus.enable_in = 1'b0;
        bus.sof       = 1'b0;
        bus.bpm_in    = 8'd0;
        bus.bpm_valid = 1'b0;
        bus.amp_in    = 8'd0;
        bus.beat_in   = 1'b0;
        reset_n       = 1'b0;
        step(3);
        check("rst_period", int'(bus.period_ms), 1500);
        check("rst_bpm_est", int'(bus.bpm_estimate), 40);
        check("rst_amp", int'(bus.pulse_amplitude), 0);
        check("rst_trig", int'(bus.beat_trigger), 0);
        check("rst_filter", int'(bus.filter_enable), 0);
        check("rst_locked", int'(bus.locked), 0);
        reset_n = 1'b1;
        step(2);
        prev_per  = int'(bus.period_ms);
        prev_est  = int'({bus.bpm_estimate, bus.pulse_amplitude});
        prev_lck  = int'(bus.locked);
        prev_trig = int'(bus.beat_trigger);
        rise_cyc  = 0;
        exp_len   = TRIG_LEN;
        armed     = 1'b1;

        bpm_req(120, 500);             step(20);
        sof_pulse(8'h5A, 120);         step(3);
        bpm_req(250, 300);             step(20);
        // sof together with bpm_valid: estimate takes the earlier clamp (200)
        bus.sof       = 1'b1;
        bus.amp_in    = 8'h33;
        bus.bpm_in    = 8'd0;
        bus.bpm_valid = 1'b1;
        est_q.push_back('{cyc + 1, 200 * 256 + 8'h33});
        per_q.push_back('{cyc + 17, 1500});
        step(1);
        bus.sof       = 1'b0;
        bus.bpm_valid = 1'b0;
        step(20);
        sof_pulse(8'h33, 40);          step(3);

        // second request arrives mid-divide and is queued
        bus.bpm_in    = 8'd60;
        bus.bpm_valid = 1'b1;
        per_q.push_back('{cyc + 17, 1000});
        per_q.push_back('{cyc + 34, 600});
        step(1);
        bus.bpm_valid = 1'b0;
        step(2);
        bus.bpm_in    = 8'd100;
        bus.bpm_valid = 1'b1;
        step(1);
        bus.bpm_valid = 1'b0;
        step(40);

        bpm_req(120, 500);             step(20);
        check("idle_filter", int'(bus.filter_enable), 0);

        bus.enable_in = 1'b1;
        t0 = cyc + 1;
        beat_q.push_back('{t0, TRIG_LEN});
        beat_q.push_back('{t0 + 500 * MS, TRIG_LEN});
        beat_q.push_back('{t0 + 1000 * MS, TRIG_LEN});
        step(1);
        check("free_filter", int'(bus.filter_enable), 1);
        check("free_locked", int'(bus.locked), 0);
`ifndef ADSR_SCHED_EXT_LOCK_EN
        wait_until(t0 + 200 * MS);
        ext_beat(1'b0, 1'b0);
`endif
        wait_until(t0 + 1000 * MS + 100);

`ifdef ADSR_SCHED_EXT_LOCK_EN
        wait_until(t0 + 1000 * MS + 500);
        b2 = cyc + 1;
        ext_beat(1'b1, 1'b1);
        wait_until(b2 + 100 * MS - 1);
        ext_beat(1'b0, 1'b0);
        wait_until(b2 + 250 * MS - 1);
        ext_beat(1'b0, 1'b0);
        b3 = cyc + 1;
        ext_beat(1'b1, 1'b0);
        check("lock_held", int'(bus.locked), 1);
        beat_q.push_back('{b3 + 1000 * MS, TRIG_LEN});
        lck_q.push_back('{b3 + 1000 * MS, 0});
        wait_until(b3 + 1000 * MS + 100);
`endif

        bus.enable_in = 1'b0;
        step(5);
        check("off_filter", int'(bus.filter_enable), 0);
        check("off_locked", int'(bus.locked), 0);
        bus.enable_in = 1'b1;
        k = cyc;
        beat_q.push_back('{k + 1, 10});
        step(10);
        bus.enable_in = 1'b0;
        step(1);
        check("drop_trig", int'(bus.beat_trigger), 0);
        check("drop_filter", int'(bus.filter_enable), 0);
        step(5);

        check("left_period", per_q.size(), 0);
        check("left_est", est_q.size(), 0);
        check("left_locked", lck_q.size(), 0);
        check("left_beats", beat_q.size(), 0);
        armed = 1'b0;

        // reset while a divide and a trigger are in flight
        bus.enable_in = 1'b1;
        bus.bpm_in    = 8'd60;
        bus.bpm_valid = 1'b1;
        step(1);
        bus.bpm_valid = 1'b0;
        step(5);
        check("pre_rst_trig", int'(bus.beat_trigger), 1);
        bus.enable_in = 1'b0;
        reset_n       = 1'b0;
        #2;
        check("mid_rst_period", int'(bus.period_ms), 1500);
        check("mid_rst_trig", int'(bus.beat_trigger), 0);
        check("mid_rst_filter", int'(bus.filter_enable), 0);
        check("mid_rst_est", int'(bus.bpm_estimate), 40);
        step(2);
        reset_n = 1'b1;
        step(30);
        check("post_rst_period", int'(bus.period_ms), 1500);
        check("post_rst_trig", int'(bus.beat_trigger), 0);
        check("post_rst_state", int'(dut.state_q), int'(S_IDLE));
        bus.enable_in = 1'b1;
        step(1);
        check("reenable_trig", int'(bus.beat_trigger), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
